// File: rtl/ps2_mmio_fifo_bridge.sv
// PS/2 host-side bridge: RX/TX byte FIFOs behind the MMIO register window,
// with a byte-at-a-time handshake towards the PS/2 link state machine.
//
// Ports:
//   main_clk, reset           system clock, synchronous active-high reset
//   address_mmio[2:0]         register address within the PS/2 window
//   data_write_mmio[7:0]      MMIO write data
//   is_mmio_write             one-cycle write strobe
//   data_read_mmio[7:0]       registered read data (1-cycle latency)
//   rx_byte[7:0], rx_valid    received byte and its one-cycle valid pulse
//   tx_byte[7:0], tx_pending  TX FIFO head and "byte waiting" level
//   tx_done                   one-cycle pulse: link stage sent tx_byte
//   device_connected          level from link stage: device present
module ps2_mmio_fifo_bridge #(
    parameter int RX_CAPACITY = 255,
    parameter int TX_CAPACITY = 255
) (
    input  logic       main_clk,
    input  logic       reset,
    input  logic [2:0] address_mmio,
    input  logic [7:0] data_write_mmio,
    input  logic       is_mmio_write,
    output logic [7:0] data_read_mmio,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    output logic [7:0] tx_byte,
    output logic       tx_pending,
    input  logic       tx_done,
    input  logic       device_connected
);

    // Storage is the capacity rounded up to a power of two.
    localparam int RX_AW    = (RX_CAPACITY <= 1) ? 1 : $clog2(RX_CAPACITY);
    localparam int TX_AW    = (TX_CAPACITY <= 1) ? 1 : $clog2(TX_CAPACITY);
    localparam int RX_DEPTH = 1 << RX_AW;
    localparam int TX_DEPTH = 1 << TX_AW;

    localparam logic [7:0] RX_CAP = 8'(RX_CAPACITY);
    localparam logic [7:0] TX_CAP = 8'(TX_CAPACITY);

    localparam logic [2:0] A_DATA  = 3'b000;
    localparam logic [2:0] A_PUSH  = 3'b001;
    localparam logic [2:0] A_RXCNT = 3'b010;
    localparam logic [2:0] A_TXCNT = 3'b011;
    localparam logic [2:0] A_CONN  = 3'b100;
    localparam logic [2:0] A_DROP  = 3'b110;

    logic [7:0] rx_mem [RX_DEPTH];
    logic [7:0] tx_mem [TX_DEPTH];

    logic [RX_AW-1:0] rx_rd_q, rx_rd_d;
    logic [RX_AW-1:0] rx_wr_q, rx_wr_d;
    logic [7:0]       rx_count_q, rx_count_d;
    logic [TX_AW-1:0] tx_rd_q, tx_rd_d;
    logic [TX_AW-1:0] tx_wr_q, tx_wr_d;
    logic [7:0]       tx_count_q, tx_count_d;
    logic             drop_q, drop_d;
    logic             tx_pending_q, tx_pending_d;
    logic [7:0]       rd_data_q, rd_data_d;

    logic wr_pop, wr_push, wr_clear;
    logic rx_pop, rx_push, drop_set;
    logic tx_pop, tx_push;

    always_comb begin
        wr_pop   = is_mmio_write && (address_mmio == A_DATA);
        wr_push  = is_mmio_write && (address_mmio == A_PUSH);
        wr_clear = is_mmio_write && (address_mmio == A_DROP);

        // A same-cycle pop frees the slot the incoming byte needs.
        rx_pop   = wr_pop && (rx_count_q != 8'd0);
        rx_push  = rx_valid && ((rx_count_q < RX_CAP) || rx_pop);
        drop_set = rx_valid && !rx_push;

        tx_pop   = tx_done && (tx_count_q != 8'd0);
        tx_push  = wr_push && device_connected && (tx_count_q < TX_CAP);

        rx_rd_d = rx_pop  ? rx_rd_q + RX_AW'(1) : rx_rd_q;
        rx_wr_d = rx_push ? rx_wr_q + RX_AW'(1) : rx_wr_q;
        unique case ({rx_push, rx_pop})
            2'b10:   rx_count_d = rx_count_q + 8'd1;
            2'b01:   rx_count_d = rx_count_q - 8'd1;
            default: rx_count_d = rx_count_q;
        endcase

        tx_rd_d = tx_pop  ? tx_rd_q + TX_AW'(1) : tx_rd_q;
        tx_wr_d = tx_push ? tx_wr_q + TX_AW'(1) : tx_wr_q;
        unique case ({tx_push, tx_pop})
            2'b10:   tx_count_d = tx_count_q + 8'd1;
            2'b01:   tx_count_d = tx_count_q - 8'd1;
            default: tx_count_d = tx_count_q;
        endcase

        // No device: anything queued for it is stale, flush every cycle.
        if (!device_connected) begin
            tx_rd_d    = tx_wr_q;
            tx_count_d = 8'd0;
        end

        tx_pending_d = (tx_count_d != 8'd0) && device_connected;

        // Set beats clear so a byte lost in the clearing cycle is reported.
        if (drop_set) begin
            drop_d = 1'b1;
        end else if (wr_clear) begin
            drop_d = 1'b0;
        end else begin
            drop_d = drop_q;
        end

        case (address_mmio)
            A_DATA:  rd_data_d = (rx_count_q == 8'd0) ? 8'h00
                                                      : rx_mem[rx_rd_q];
            A_RXCNT: rd_data_d = rx_count_q;
            A_TXCNT: rd_data_d = tx_count_q;
            A_CONN:  rd_data_d = {7'b0, device_connected};
            A_DROP:  rd_data_d = {7'b0, drop_q};
            default: rd_data_d = 8'h00;
        endcase
    end

    always_ff @(posedge main_clk) begin
        if (reset) begin
            rx_rd_q      <= '0;
            rx_wr_q      <= '0;
            rx_count_q   <= 8'd0;
            tx_rd_q      <= '0;
            tx_wr_q      <= '0;
            tx_count_q   <= 8'd0;
            drop_q       <= 1'b0;
            tx_pending_q <= 1'b0;
            rd_data_q    <= 8'h00;
        end else begin
            rx_rd_q      <= rx_rd_d;
            rx_wr_q      <= rx_wr_d;
            rx_count_q   <= rx_count_d;
            tx_rd_q      <= tx_rd_d;
            tx_wr_q      <= tx_wr_d;
            tx_count_q   <= tx_count_d;
            drop_q       <= drop_d;
            tx_pending_q <= tx_pending_d;
            rd_data_q    <= rd_data_d;
        end
    end

    // Storage needs no reset: the pointers and counts define validity.
    always_ff @(posedge main_clk) begin
        if (rx_push) begin
            rx_mem[rx_wr_q] <= rx_byte;
        end
        if (tx_push) begin
            tx_mem[tx_wr_q] <= data_write_mmio;
        end
    end

    assign data_read_mmio = rd_data_q;
    assign tx_pending     = tx_pending_q;
    assign tx_byte        = (tx_count_q == 8'd0) ? 8'h00 : tx_mem[tx_rd_q];

endmodule
